// File: rtl/datapath.sv
// Single-cycle 32-bit MIPS-subset processor with fixed 64-word program ROM,
// 32x32 register file and 64x32 data memory; WriteData exposes the write-back mux.
module datapath (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] WriteData
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q  [32];
  logic [31:0] mem_q [64];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_addr;
  logic [31:0] imm_ext, rs_val, rt_val, alu_b, alu_res, mem_rdata, pc_plus4;

  logic    reg_dst, alu_src, mem_to_reg, reg_write, mem_write, branch, jump;
  alu_op_e alu_ctrl;

  always_comb begin
    instr = '0;
    case (pc_q[7:2])
      6'd0:    instr = 32'h2001_0005;
      6'd1:    instr = 32'h2002_0003;
      6'd2:    instr = 32'h0022_1820;
      6'd3:    instr = 32'h0022_2022;
      6'd4:    instr = 32'hAC03_0004;
      6'd5:    instr = 32'h8C05_0004;
      6'd6:    instr = 32'h0041_302A;
      6'd7:    instr = 32'h10A3_0001;
      6'd8:    instr = 32'h2007_0063;
      6'd9:    instr = 32'h0800_0009;
      default: instr = '0;
    endcase
  end

  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          FN_ADD:  begin alu_ctrl = ALU_ADD; reg_write = 1'b1; end
          FN_SUB:  begin alu_ctrl = ALU_SUB; reg_write = 1'b1; end
          FN_AND:  begin alu_ctrl = ALU_AND; reg_write = 1'b1; end
          FN_OR:   begin alu_ctrl = ALU_OR;  reg_write = 1'b1; end
          FN_SLT:  begin alu_ctrl = ALU_SLT; reg_write = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin alu_src = 1'b1; reg_write = 1'b1; end
      OP_LW:   begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  begin alu_ctrl = ALU_SUB; branch = 1'b1; end
      OP_J:    begin alu_src = 1'b1; jump = 1'b1; end
      default: ;
    endcase
  end

  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];
  assign alu_b  = alu_src ? imm_ext : rt_val;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'b0, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  assign mem_rdata = mem_q[alu_res[7:2]];
  assign WriteData = mem_to_reg ? mem_rdata : alu_res;
  assign wr_addr   = reg_dst ? rd : rt;
  assign pc_plus4  = pc_q + 32'd4;

  // beq compares via the ALU subtract: equal operands give a zero result
  always_comb begin
    pc_d = pc_plus4;
    if (jump)
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && (alu_res == '0))
      pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      rf_q <= '{default: '0};
    else if (reg_write && (wr_addr != 5'd0))
      rf_q[wr_addr] <= WriteData;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      mem_q <= '{default: '0};
    else if (mem_write)
      mem_q[alu_res[7:2]] <= rt_val;
  end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: instruction-level ISA model checked every cycle, plus
// literal expectations for the reference program and randomized async resets.
module tb_datapath;

  logic        Clk;
  logic        Rst;
  logic [31:0] WriteData;

  int errors = 0;
  int checks = 0;

  datapath dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .WriteData (WriteData)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic [31:0] m_rom [64];
  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(int target);
    return {6'h02, target[25:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = '0;
    foreach (m_rf[i])  m_rf[i]  = '0;
    foreach (m_mem[i]) m_mem[i] = '0;
  endtask

  // Architectural effect of the instruction at m_pc, without committing it
  task automatic m_eval(output logic [31:0] wd, output logic [31:0] npc,
                        output int wreg, output bit mwr, output int maddr,
                        output logic [31:0] mdata);
    logic [31:0] ins, a, b, imm;
    ins   = m_rom[m_pc[7:2]];
    a     = m_rf[ins[25:21]];
    b     = m_rf[ins[20:16]];
    imm   = {{16{ins[15]}}, ins[15:0]};
    npc   = m_pc + 4;
    wreg  = -1;
    mwr   = 1'b0;
    wd    = a + imm;
    maddr = int'((a + imm) >> 2) % 64;
    mdata = b;
    case (ins[31:26])
      6'h00: begin
        wd = a + b;
        case (ins[5:0])
          6'h20: begin wd = a + b; wreg = ins[15:11]; end
          6'h22: begin wd = a - b; wreg = ins[15:11]; end
          6'h24: begin wd = a & b; wreg = ins[15:11]; end
          6'h25: begin wd = a | b; wreg = ins[15:11]; end
          6'h2A: begin wd = ($signed(a) < $signed(b)) ? 1 : 0; wreg = ins[15:11]; end
          default: ;
        endcase
      end
      6'h08: wreg = ins[20:16];
      6'h23: begin wd = m_mem[maddr]; wreg = ins[20:16]; end
      6'h2B: mwr = 1'b1;
      6'h04: begin
        wd = a - b;
        if (a == b) npc = m_pc + 4 + (imm << 2);
      end
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
  endtask

  task automatic m_step();
    logic [31:0] wd, npc, mdata;
    int wreg, maddr;
    bit mwr;
    m_eval(wd, npc, wreg, mwr, maddr, mdata);
    if (wreg > 0) m_rf[wreg] = wd;
    if (mwr) m_mem[maddr] = mdata;
    m_pc = npc;
  endtask

  always @(posedge Clk or posedge Rst) begin
    if (Rst) m_reset();
    else     m_step();
  end

  always @(negedge Clk) begin
    logic [31:0] wd, npc, mdata;
    int wreg, maddr, nmis;
    bit mwr;
    m_eval(wd, npc, wreg, mwr, maddr, mdata);
    check("cyc_writedata", WriteData, wd);
    check("cyc_pc", dut.pc_q, m_pc);
    nmis = 0;
    for (int i = 1; i < 32; i++) if (dut.rf_q[i] !== m_rf[i]) nmis++;
    for (int i = 0; i < 64; i++) if (dut.mem_q[i] !== m_mem[i]) nmis++;
    check("cyc_state_mismatches", nmis, 0);
  end

  function automatic int nonzero_state();
    int n = 0;
    for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'd0) n++;
    for (int i = 0; i < 64; i++) if (dut.mem_q[i] !== 32'd0) n++;
    return n;
  endfunction

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_wd [8];
    exp_wd = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd4, 32'd8, 32'd1, 32'd0};

    foreach (m_rom[i]) m_rom[i] = '0;
    m_rom[0] = enc_i(8'h08, 0, 1, 5);
    m_rom[1] = enc_i(8'h08, 0, 2, 3);
    m_rom[2] = enc_r(1, 2, 3, 8'h20);
    m_rom[3] = enc_r(1, 2, 4, 8'h22);
    m_rom[4] = enc_i(8'h2B, 0, 3, 4);
    m_rom[5] = enc_i(8'h23, 0, 5, 4);
    m_rom[6] = enc_r(2, 1, 6, 8'h2A);
    m_rom[7] = enc_i(8'h04, 5, 3, 1);
    m_rom[8] = enc_i(8'h08, 0, 7, 99);
    m_rom[9] = enc_j(9);
    m_reset();
    Rst = 1'b1;

    repeat (100) begin
      @(negedge Clk);
      #1;
      if (dut.pc_q !== 32'd0 || WriteData !== 32'd5 || nonzero_state() != 0) begin
        check("rst_hold_pc", dut.pc_q, 32'd0);
        check("rst_hold_wd", WriteData, 32'd5);
        check("rst_hold_state", nonzero_state(), 0);
      end
    end
    check("rst_hold_wd_end", WriteData, 32'd5);
    check("rst_hold_pc_end", dut.pc_q, 32'd0);

    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge Clk);
      #1;
      check($sformatf("prog_wd_%0d", k), WriteData, exp_wd[k]);
    end
    check("beq_pc", dut.pc_q, 32'h1C);
    @(negedge Clk);
    #1;
    check("after_beq_pc", dut.pc_q, 32'h24);
    check("skip_r7", dut.rf_q[7], 32'd0);
    repeat (5) @(negedge Clk);
    #1;
    check("steady_pc", dut.pc_q, 32'h24);
    check("steady_wd", WriteData, 32'd9);
    check("r1", dut.rf_q[1], 32'd5);
    check("r2", dut.rf_q[2], 32'd3);
    check("r3", dut.rf_q[3], 32'd8);
    check("r4", dut.rf_q[4], 32'd2);
    check("r5", dut.rf_q[5], 32'd8);
    check("r6", dut.rf_q[6], 32'd1);
    check("r7", dut.rf_q[7], 32'd0);
    check("mem1", dut.mem_q[1], 32'd8);

    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 30)) @(posedge Clk);
      #($urandom_range(1, 4));
      Rst = 1'b1;
      #1;
      check("async_rst_pc", dut.pc_q, 32'd0);
      check("async_rst_state", nonzero_state(), 0);
      check("async_rst_wd", WriteData, 32'd5);
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      @(negedge Clk);
      #($urandom_range(0, 3));
      Rst = 1'b0;
    end

    repeat (15) @(negedge Clk);
    #1;
    check("final_pc", dut.pc_q, 32'h24);
    check("final_r3", dut.rf_q[3], 32'd8);
    summary();
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  asynchronous, active-high reset; clears PC, register file and data memory immediately.
REQ-003 WriteData  output  32  write-back mux output for the current instruction: memory read data when MemtoReg, else ALU result; driven every cycle regardless of RegWrite.

Function
REQ-004 The block SHALL be a single-cycle 32-bit MIPS-subset processor: every instruction fetches, executes and commits in one Clk cycle.
REQ-005 PC SHALL be a 32-bit byte address, reset to 0x00000000.
REQ-006 Instruction ROM SHALL be 64 x 32 bits, read combinationally at index PC[7:2].
REQ-007 Unlisted ROM words SHALL be 0x00000000, executed as a NOP.
REQ-008 Register file SHALL be 32 x 32 bits with two combinational read ports and one write port written on the rising edge.
REQ-009 Register $0 SHALL always read 0; writes to $0 are discarded.
REQ-010 Data memory SHALL be 64 x 32 bits, indexed by ALU result [7:2], with combinational read and rising-edge write.
REQ-011 Supported opcodes: R-type 0x00; addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-012 R-type funct codes: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed compare, result 1 or 0).
REQ-013 R-type funct 0x00, other funct values and unknown opcodes SHALL perform no register write and no memory write; PC advances by 4.
REQ-014 R-type SHALL write rd; addi and lw SHALL write rt.
REQ-015 The immediate SHALL be sign-extended to 32 bits.
REQ-016 addi, lw, sw and j SHALL use ALU add of rs and the immediate.
REQ-017 beq SHALL use ALU sub of rs and rt.
REQ-018 ALU arithmetic SHALL wrap modulo 2^32 with no overflow trap.
REQ-019 lw SHALL write mem[rs+imm] to rt.
REQ-020 sw SHALL write rt to mem[rs+imm] and write no register.
REQ-021 Next PC SHALL be PC+4 by default.
REQ-022 When beq has rs==rt, next PC SHALL be PC+4+(imm<<2).
REQ-023 For j, next PC SHALL be {PC+4[31:28], target26, 2'b00}.
REQ-024 ROM contents SHALL be fixed, word index: encoding:
- 0: addi $1,$0,5
- 1: addi $2,$0,3
- 2: add $3,$1,$2
- 3: sub $4,$1,$2
- 4: sw $3,4($0)
- 5: lw $5,4($0)
- 6: slt $6,$2,$1
- 7: beq $5,$3,+1
- 8: addi $7,$0,99
- 9: j 9 (0x08000009)
- 10-63: 0.
REQ-025 Internal control SHALL be purely combinational decode of opcode/funct: RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, ALU control.

Reset
REQ-026 While Rst is high, PC SHALL be 0 and no register or memory write SHALL occur.
REQ-027 While Rst is high, WriteData SHALL combinationally reflect ROM word 0 with zeroed registers, i.e. 5.
REQ-028 After Rst deasserts, the first rising edge SHALL commit instruction 0.
REQ-029 Reset asserted mid-program SHALL immediately return PC to 0 and clear all registers and memory.

Verification
REQ-030 Hold Rst high for 100 cycles -> PC=0, WriteData=5, $1..$31=0 throughout.
REQ-031 Release Rst -> WriteData per cycle = 5, 3, 8, 2, 4 (sw address), 8, 1, 0 (beq).
REQ-032 After the beq cycle -> PC steps 0x1C to 0x24, instruction 8 is skipped, $7 stays 0.
REQ-033 Steady state after release -> PC holds 0x24, WriteData=9 every cycle, no further register or memory writes.
REQ-034 At steady state -> $1=5, $2=3, $3=8, $4=2, $5=8, $6=1, mem[1]=8.
REQ-035 Assert Rst asynchronously between edges mid-run -> PC=0 and registers=0 before the next edge, then the program re-runs identically.
